// File: rtl/prom_pkg.sv
// Shared types and constants for the fused-PROM reader: FSM states, packing helpers,
// wait-counter sizing and the N2V reference image.
package prom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        EMIT,
        DONE
    } state_t;

    // The wait counter is sized for the largest legal access time (15 cycles).
    localparam int ACCESS_CYC_MAX = 15;
    localparam int WAIT_W         = $clog2(ACCESS_CYC_MAX + 1);

    // N2V PROM contents, entry i at bits [2*i +: 2]; byte k of the dump at bits [8*k +: 8].
    localparam logic [63:0] N2V_IMAGE = 64'h7FFF_FFFF_D57F_FFF1;

    function automatic int entries_per_byte(input int data_w);
        return 8 / data_w;
    endfunction

    function automatic int slot_width(input int epb);
        return (epb > 1) ? $clog2(epb) : 1;
    endfunction

endpackage

// File: rtl/prom_pack.sv
// Byte assembly register: inserts one PROM entry into its slot and clears between bytes.
module prom_pack #(
    parameter int DATA_W = 2,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [SLOT_W-1:0] slot,
    input  logic [DATA_W-1:0] din,
    output logic [7:0]        pack
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack <= '0;
        end else if (clear) begin
            pack <= '0;
        end else if (load) begin
            pack[DATA_W*slot +: DATA_W] <= din;
        end
    end

endmodule

// File: rtl/prom_reader.sv
// Walks every PROM address, samples the data after the access time, packs entries into
// bytes and streams them over valid/ready with a running mod-256 checksum.
module prom_reader
    import prom_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 2,
    parameter int ACCESS_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              prom_ce_n,
    output logic [ADDR_W-1:0] prom_a,
    input  logic [DATA_W-1:0] prom_d,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        checksum
);

    localparam int                EPB       = entries_per_byte(DATA_W);
    localparam int                SLOT_W    = slot_width(EPB);
    localparam logic [ADDR_W-1:0] LAST_A    = '1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ACCESS_CYC - 1);

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SLOT_W-1:0] slot;
    logic              last_slot;
    logic              access_end;
    logic              pack_clear;
    logic [7:0]        pack;

    assign slot       = SLOT_W'(int'(prom_a) % EPB);
    assign last_slot  = (int'(slot) == EPB - 1);
    assign access_end = (state == ACCESS) && (wait_cnt == '0);

    // Outputs decode straight from state, so ce_n can only be low inside ACCESS.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign prom_ce_n = (state != ACCESS);
    assign out_valid = (state == EMIT);
    assign out_data  = pack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        pack_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = SETUP;
                    pack_clear = 1'b1;
                end
            end
            SETUP:  state_nx = ACCESS;
            ACCESS: begin
                if (wait_cnt == '0) begin
                    state_nx = last_slot ? EMIT : SETUP;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pack_clear = 1'b1;
                    state_nx   = (prom_a == LAST_A) ? DONE : SETUP;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prom_a   <= '0;
            checksum <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        prom_a   <= '0;
                        checksum <= '0;
                    end
                end
                SETUP: wait_cnt <= WAIT_LOAD;
                ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (!last_slot) begin
                        prom_a <= prom_a + 1'b1;
                    end
                end
                EMIT: begin
                    // The last address ends the scan instead of wrapping back to zero.
                    if (out_ready) begin
                        checksum <= checksum + pack;
                        if (prom_a != LAST_A) begin
                            prom_a <= prom_a + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    prom_pack #(
        .DATA_W(DATA_W),
        .SLOT_W(SLOT_W)
    ) u_pack (
        .clk  (clk),
        .rst  (rst),
        .clear(pack_clear),
        .load (access_end),
        .slot (slot),
        .din  (prom_d),
        .pack (pack)
    );

endmodule

// File: tb/tb_prom_reader.sv
// Bench for prom_reader: three instances (access time 3, 1 and 7) read an N2V PROM model;
// a queue-based scoreboard checks every accepted byte and the final checksum.
module tb_prom_reader;
    import prom_pkg::*;

    localparam int N = 3;

    function automatic int acc_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 7);
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        start     [N];
    logic        out_ready [N];
    logic        busy      [N];
    logic        done      [N];
    logic        prom_ce_n [N];
    logic        out_valid [N];
    logic [4:0]  prom_a    [N];
    logic [1:0]  prom_d    [N];
    logic [7:0]  out_data  [N];
    logic [7:0]  checksum  [N];

    logic [63:0] image = N2V_IMAGE;
    logic [7:0]  exp_bytes [8] = '{8'hF1, 8'hFF, 8'h7F, 8'hD5, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    logic [7:0]  exp_sum = 8'hC0;

    logic [7:0]  exp_q [N][$];
    logic [7:0]  sum_q [N][$];
    int          done_seen [N];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        int low_cnt;

        prom_reader #(
            .ADDR_W    (5),
            .DATA_W    (2),
            .ACCESS_CYC(acc_of(g))
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .prom_ce_n(prom_ce_n[g]),
            .prom_a   (prom_a[g]),
            .prom_d   (prom_d[g]),
            .out_data (out_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .checksum (checksum[g])
        );

        // PROM model: unknown data until ce_n has been low for the full access time.
        always @(posedge clk or posedge rst) begin
            if (rst || prom_ce_n[g]) low_cnt <= 0;
            else                     low_cnt <= low_cnt + 1;
        end
        assign prom_d[g] = (!prom_ce_n[g] && low_cnt >= acc_of(g) - 1)
                           ? image[2*prom_a[g] +: 2] : 2'bxx;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Scoreboard monitor: pops on every accepted byte and on every done pulse.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst && out_valid[i] && out_ready[i]) begin
                if (exp_q[i].size() == 0) fail_now($sformatf("byte_u%0d", i), "unexpected byte");
                else check($sformatf("byte_u%0d", i), out_data[i], exp_q[i].pop_front());
            end
            if (!rst && done[i]) begin
                done_seen[i]++;
                if (sum_q[i].size() == 0) fail_now($sformatf("done_u%0d", i), "unexpected done");
                else check($sformatf("checksum_u%0d", i), checksum[i], sum_q[i].pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan(input int i);
        for (int k = 0; k < 8; k++) exp_q[i].push_back(exp_bytes[k]);
        sum_q[i].push_back(exp_sum);
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string name);
        int n = 0;
        while (!done[i] && n < 3000) begin
            step();
            n++;
        end
        if (!done[i]) fail_now(name, "timeout waiting for done");
    endtask

    task automatic wait_valid(input int i, input string name);
        int n = 0;
        while (!out_valid[i] && n < 3000) begin
            step();
            n++;
        end
        if (!out_valid[i]) fail_now(name, "timeout waiting for out_valid");
    endtask

    task automatic check_reset_state(input string name);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_u%0d", name, i),
                  {busy[i], done[i], prom_ce_n[i], out_valid[i], prom_a[i], out_data[i], checksum[i]},
                  {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 8'h00});
    endtask

    initial begin
        int t0;
        int act;
        int stall_err;
        logic [7:0] d0;
        logic [4:0] a0;

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            start[i]     = 1'b0;
            out_ready[i] = 1'b1;
            done_seen[i] = 0;
        end
        step();
        step();
        check_reset_state("reset");

        // start coinciding with rst is lost
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        rst      = 1'b0;
        step();
        check("start_during_rst", busy[0], 1'b0);

        act = 0;
        repeat (100) begin
            step();
            for (int i = 0; i < N; i++)
                if (busy[i] || done[i] || !prom_ce_n[i] || out_valid[i]) act++;
        end
        check("idle_activity", act, 0);

        // Full scan with out_ready high, then a start pulse during DONE.
        push_scan(0);
        t0 = cyc;
        pulse_start(0);
        wait_done(0, "scan_done");
        check("scan_latency", cyc - t0, 137);
        pulse_start(0);
        step();
        check("start_in_done_ignored", busy[0], 1'b0);
        check("done_once", done_seen[0], 1);
        check("scan_queue_empty", exp_q[0].size(), 0);

        // Backpressure: 20 stalled cycles on every byte.
        out_ready[0] = 1'b0;
        push_scan(0);
        pulse_start(0);
        for (int b = 0; b < 8; b++) begin
            wait_valid(0, "bp_valid");
            d0 = out_data[0];
            a0 = prom_a[0];
            stall_err = 0;
            repeat (20) begin
                step();
                if (out_data[0] !== d0 || prom_a[0] !== a0 || prom_ce_n[0] !== 1'b1 || out_valid[0] !== 1'b1)
                    stall_err++;
            end
            check($sformatf("bp_stall_stable_b%0d", b), stall_err, 0);
            out_ready[0] = 1'b1;
            step();
            out_ready[0] = 1'b0;
        end
        out_ready[0] = 1'b1;
        wait_done(0, "bp_done");
        check("bp_queue_empty", exp_q[0].size(), 0);
        step();

        // Access times 1 and 7 on the other two instances, run together.
        push_scan(1);
        push_scan(2);
        t0 = cyc;
        start[1] = 1'b1;
        start[2] = 1'b1;
        step();
        start[1] = 1'b0;
        start[2] = 1'b0;
        wait_done(1, "acc1_done");
        check("acc1_latency", cyc - t0, 73);
        wait_done(2, "acc7_done");
        check("acc7_latency", cyc - t0, 265);
        step();

        // Start re-pulsed mid-scan must not restart the scan.
        push_scan(0);
        t0 = cyc;
        pulse_start(0);
        repeat (40) step();
        pulse_start(0);
        wait_done(0, "restart_done");
        check("restart_ignored_latency", cyc - t0, 137);
        step();
        step();
        check("restart_idle", busy[0], 1'b0);

        // rst during the third EMIT, then a clean scan.
        out_ready[0] = 1'b0;
        push_scan(0);
        pulse_start(0);
        for (int b = 0; b < 2; b++) begin
            wait_valid(0, "rst_valid");
            out_ready[0] = 1'b1;
            step();
            out_ready[0] = 1'b0;
        end
        wait_valid(0, "rst_third_emit");
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid_scan");
        exp_q[0].delete();
        sum_q[0].delete();
        step();
        rst = 1'b0;
        step();
        out_ready[0] = 1'b1;
        push_scan(0);
        t0 = cyc;
        pulse_start(0);
        wait_done(0, "post_rst_done");
        check("post_rst_latency", cyc - t0, 137);
        step();

        for (int i = 0; i < N; i++) begin
            check($sformatf("leftover_bytes_u%0d", i), exp_q[i].size(), 0);
            check($sformatf("leftover_sums_u%0d", i), sum_q[i].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
